// File: rtl/wght_glb_streamer.sv
// wght_glb_streamer
//
// Weight-path source stage. A start command reads a contiguous run of weight
// words from the weight global-buffer SRAM. The words are streamed over an
// enable/ready/data handshake into router_wght source port 0. A 2-entry
// output FIFO hides the 1-cycle SRAM read latency. The stream therefore
// sustains one word per cycle while the router holds ready high.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        start pulse, sampled only while idle
//   base_addr_i    first SRAM address of the run
//   count_i        number of words in the run (0 gives an immediate done)
//   busy_o         high while a run is in progress
//   done_o         one-cycle pulse at the end of a run
//   mem_rd_en_o    SRAM read strobe
//   mem_addr_o     SRAM read address
//   mem_rd_data_i  SRAM read data, valid the cycle after mem_rd_en_o
//   data_o         word to the router (0 when nothing is buffered)
//   enable_o       data_o is valid
//   ready_i        router accepts the word on this edge
module wght_glb_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  enable_o,
    input  logic                  ready_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [ADDR_WIDTH:0]   reads_left_q, reads_left_nxt;
    logic                  done_q, done_nxt;
    logic                  inflight_q;
    logic [1:0]            fifo_cnt_q, fifo_cnt_nxt;
    logic                  wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_mem [2];

    logic                  push, pop, issue;
    logic [1:0]            occupancy;

    // FIFO handshake terms. enable_o depends only on registered state, so
    // the router never sees a combinational path from ready_i back to enable_o.
    assign enable_o  = (fifo_cnt_q != 2'd0);
    assign pop       = enable_o & ready_i;
    assign push      = inflight_q;
    assign occupancy = fifo_cnt_q + {1'b0, inflight_q};

    // A read is issued only if its word is guaranteed a FIFO slot when the
    // data returns. A slot is guaranteed if one is free now, or if the head
    // leaves on this same edge.
    assign issue = (state_q == S_STREAM) && (reads_left_q != '0) &&
                   ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));

    assign fifo_cnt_nxt = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign mem_rd_en_o = issue;
    assign mem_addr_o  = addr_q;
    assign data_o      = enable_o ? fifo_mem[rd_ptr_q] : '0;

    // NOTE: every variable gets a default at the top of the block. Without
    // the defaults, a branch that skips an assignment would infer a latch.
    always_comb begin
        state_nxt      = state_q;
        addr_nxt       = addr_q;
        reads_left_nxt = reads_left_q;
        done_nxt       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_nxt       = base_addr_i;
                    reads_left_nxt = count_i;
                    if (count_i == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (issue) begin
                    addr_nxt       = addr_q + ADDR_WIDTH'(1);
                    reads_left_nxt = reads_left_q - (ADDR_WIDTH+1)'(1);
                    if (reads_left_q == (ADDR_WIDTH+1)'(1)) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave on the edge that carries the final handshake. busy_o
                // then falls in the same cycle that done_o rises.
                if (fifo_cnt_nxt == 2'd0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together on the edge, whatever order the statements are in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            reads_left_q <= '0;
            done_q       <= 1'b0;
            inflight_q   <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            addr_q       <= addr_nxt;
            reads_left_q <= reads_left_nxt;
            done_q       <= done_nxt;
            inflight_q   <= issue;
            fifo_cnt_q   <= fifo_cnt_nxt;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // NOTE: the FIFO storage has no reset. data_o is gated by enable_o, and
    // fifo_cnt_q is reset, so a stale entry can never become visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rd_data_i;
        end
    end

endmodule

// File: tb/tb_wght_glb_streamer.sv
// Directed testbench for wght_glb_streamer. The bench includes a behavioural
// SRAM with a 1-cycle read latency, initialised with mem[i] = i + 1.
module tb_wght_glb_streamer;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy, done, mem_rd_en, enable, ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] data;

    logic [DW-1:0] sram [1 << AW];

    always #5 clk = ~clk;

    wght_glb_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .count_i      (count),
        .busy_o       (busy),
        .done_o       (done),
        .mem_rd_en_o  (mem_rd_en),
        .mem_addr_o   (mem_addr),
        .mem_rd_data_i(mem_rd_data),
        .data_o       (data),
        .enable_o     (enable),
        .ready_i      (ready)
    );

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rd_data <= sram[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int done_cycles = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent run
    logic [DW-1:0] got_q [$];
    logic [AW-1:0] rd_addr_q [$];
    int first_en, last_en, n_en, done_cyc, max_occ, stall_bad, issued, hs;
    logic busy_at_done;

    function automatic logic rdy_pat(input int bp, input int c);
        if (bp == 0) return 1'b1;
        case (c % 6)
            0, 3, 5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Called away from a clock edge. The start command is sampled on the
    // next rising edge (T0). Cycle c means the c-th cycle after T0.
    task automatic do_run(input logic [AW-1:0] b, input logic [AW:0] n,
                          input int bp, input int extra_start_cyc);
        logic          stalled;
        logic [DW-1:0] stall_data;
        stalled = 1'b0;
        stall_data = '0;
        got_q.delete();
        rd_addr_q.delete();
        first_en = -1; last_en = -1; n_en = 0; done_cyc = -1;
        max_occ = 0; stall_bad = 0; issued = 0; hs = 0; busy_at_done = 1'bx;
        start = 1'b1; base_addr = b; count = n;
        @(posedge clk); #1;
        start = 1'b0;
        ready = rdy_pat(bp, 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (stalled && (enable !== 1'b1 || data !== stall_data)) stall_bad++;
            stalled = 1'b0;
            if (enable === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = c;
                last_en = c;
                if (ready) begin
                    got_q.push_back(data);
                    hs++;
                end else begin
                    stalled = 1'b1;
                    stall_data = data;
                end
            end
            if (mem_rd_en === 1'b1) begin
                rd_addr_q.push_back(mem_addr);
                issued++;
            end
            if (issued - hs > max_occ) max_occ = issued - hs;
            if (done === 1'b1) begin
                done_cyc = c;
                busy_at_done = busy;
                break;
            end
            @(posedge clk); #1;
            ready = rdy_pat(bp, c + 1);
            if (c + 1 == extra_start_cyc) begin
                start = 1'b1; base_addr = 6'd40; count = 7'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_words(input string tag, input int b, input int n);
        check({tag, "_nwords"}, got_q.size(), n);
        check({tag, "_nreads"}, rd_addr_q.size(), n);
        for (int i = 0; i < n && i < got_q.size() && i < rd_addr_q.size(); i++) begin
            check({tag, "_addr"}, rd_addr_q[i], (b + i) % 64);
            check({tag, "_word"}, got_q[i], ((b + i) % 64) + 1);
        end
        check({tag, "_occ_le2"}, max_occ <= 2, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_data"}, data, 0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < (1 << AW); i++) sram[i] = DW'(i + 1);
        rst_n = 1'b0; start = 1'b0; ready = 1'b1; base_addr = '0; count = '0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic run: words 5..9, enable in cycles 2..6, done in cycle 7
        do_run(6'd4, 7'd5, 0, -1);
        check_words("basic", 4, 5);
        check("basic_first_en", first_en, 2);
        check("basic_last_en", last_en, 6);
        check("basic_n_en", n_en, 5);
        check("basic_done_cyc", done_cyc, 7);
        check("basic_busy_at_done", busy_at_done, 0);

        // Backpressure, started in the done cycle of the previous run
        do_run(6'd0, 7'd6, 1, -1);
        check_words("bp", 0, 6);
        check("bp_stall_stable", stall_bad, 0);

        @(posedge clk); #1;
        do_run(6'd62, 7'd4, 0, -1);
        check_words("wrap", 62, 4);

        @(posedge clk); #1;
        do_run(6'd0, 7'd0, 0, -1);
        check("zero_done_cyc", done_cyc, 0);
        check("zero_reads", issued, 0);
        check("zero_enable", n_en, 0);

        @(posedge clk); #1;
        do_run(6'd10, 7'd8, 0, 3);
        check_words("ignored_start", 10, 8);

        // Reset mid-run while a word is presented
        @(posedge clk); #1;
        start = 1'b1; base_addr = 6'd20; count = 7'd8;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (enable === 1'b1) seen = 1'b1;
        end
        check("midrst_enable_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_run(6'd0, 7'd2, 0, -1);
        check_words("after_rst", 0, 2);

        repeat (5) @(negedge clk);
        check("done_pulses", done_cycles, 6);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
